// File: rtl/controlador_exibe_sequencia.sv
// Plays the stored sequence (addresses 0..rodada) on the LEDs, one value per slot.
// Optional blank gap between values is enabled by defining EXIBE_GAP_EN.
module controlador_exibe_sequencia #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              parar,
  input  logic [ADDR_W-1:0] rodada,
  input  logic [DATA_W-1:0] dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam logic [TMR_W-1:0] TON_LAST = TMR_W'(T_ON - 1);

`ifdef EXIBE_GAP_EN
  localparam logic [TMR_W-1:0] TOFF_LAST = TMR_W'(T_OFF - 1);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;
`else
  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;
`endif

  estado_t           estado, estadoProx;
  logic [TMR_W-1:0]  timer;
  logic [ADDR_W-1:0] ultimo;

  logic latchUltimo, clrEnd, incEnd;
  logic loadLeds, clrLeds;
  logic clrTimer, incTimer;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      timer    <= '0;
      endereco <= '0;
      ultimo   <= '0;
      leds     <= '0;
    end else begin
      estado <= estadoProx;

      if (clrTimer)      timer <= '0;
      else if (incTimer) timer <= timer + TMR_W'(1);

      if (latchUltimo) ultimo <= rodada;

      if (clrEnd)      endereco <= '0;
      else if (incEnd) endereco <= endereco + ADDR_W'(1);

      if (clrLeds)       leds <= '0;
      else if (loadLeds) leds <= dado_mem;
    end
  end

  always_comb begin
    estadoProx  = estado;
    latchUltimo = 1'b0;
    clrEnd      = 1'b0;
    incEnd      = 1'b0;
    loadLeds    = 1'b0;
    clrLeds     = 1'b0;
    clrTimer    = 1'b0;
    incTimer    = 1'b0;

    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          estadoProx  = CARREGA;
          latchUltimo = 1'b1;
          clrEnd      = 1'b1;
          clrTimer    = 1'b1;
        end
      end
      CARREGA: begin
        estadoProx = ACESO;
        loadLeds   = 1'b1;
        clrTimer   = 1'b1;
      end
      ACESO: begin
        if (timer == TON_LAST) begin
          clrLeds  = 1'b1;
          clrTimer = 1'b1;
`ifdef EXIBE_GAP_EN
          estadoProx = APAGADO;
`else
          estadoProx = (endereco == ultimo) ? FIM : PROXIMO;
`endif
        end else begin
          incTimer = 1'b1;
        end
      end
`ifdef EXIBE_GAP_EN
      APAGADO: begin
        if (timer == TOFF_LAST) begin
          clrTimer   = 1'b1;
          estadoProx = (endereco == ultimo) ? FIM : PROXIMO;
        end else begin
          incTimer = 1'b1;
        end
      end
`endif
      PROXIMO: begin
        incEnd     = 1'b1;
        estadoProx = CARREGA;
      end
      FIM:     estadoProx = OCIOSO;
      default: estadoProx = OCIOSO;
    endcase

    // Abort overrides whatever the state decided above.
    if (parar && (estado != OCIOSO)) begin
      estadoProx  = OCIOSO;
      latchUltimo = 1'b0;
      incEnd      = 1'b0;
      loadLeds    = 1'b0;
      clrLeds     = 1'b1;
      incTimer    = 1'b0;
      clrTimer    = 1'b1;
    end
  end

  always_comb begin
    exibindo = 1'b0;
    case (estado)
      CARREGA, ACESO, PROXIMO: exibindo = 1'b1;
`ifdef EXIBE_GAP_EN
      APAGADO:                 exibindo = 1'b1;
`endif
      default:                 exibindo = 1'b0;
    endcase
  end

  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule
